spi_shift_engine: RTL and testbench



---
 rtl/spi_shift_engine.sv | 118 +++++++++++
 tb/tb_spi_shift_engine.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : spi_shift_engine
// Description : SPI mode-0 master shift engine driven by an external clk/32
//               sclk divider that it holds in reset while idle.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_shift_engine #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk_in,
    output logic                  clk_divider_reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  cs_n,
    output logic                  sclk_out,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int                 c_CNT_W = $clog2(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_TRANSFER = 2'd1;
    localparam logic [1:0] c_DONE     = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic                  r_sclk_d;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_last;
    logic [c_CNT_W-1:0]    r_bit_cnt;
    // MSB goes straight to mosi on start, so only the remaining bits are kept
    logic [DATA_WIDTH-2:0] r_tx_shift;
    logic [DATA_WIDTH-1:0] r_rx_shift;

    assign w_rise   = sclk_in & ~r_sclk_d;
    assign w_fall   = ~sclk_in & r_sclk_d;
    assign w_last   = (r_bit_cnt == c_LAST);
    assign sclk_out = sclk_in & (r_state == c_TRANSFER);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_sclk_d <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_sclk_d <= sclk_in;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:     if (start) w_next_state = c_TRANSFER;
            c_TRANSFER: if (w_fall && w_last) w_next_state = c_DONE;
            c_DONE:     w_next_state = c_IDLE;
            default:    w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_divider_reset <= 1'b1;
            cs_n              <= 1'b1;
            busy              <= 1'b0;
            done              <= 1'b0;
            mosi              <= 1'b0;
            rx_data           <= '0;
            r_bit_cnt         <= '0;
            r_tx_shift        <= '0;
            r_rx_shift        <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_tx_shift        <= tx_data[DATA_WIDTH-2:0];
                        mosi              <= tx_data[DATA_WIDTH-1];
                        cs_n              <= 1'b0;
                        busy              <= 1'b1;
                        clk_divider_reset <= 1'b0;
                        r_bit_cnt         <= '0;
                    end
                end
                c_TRANSFER: begin
                    if (w_rise) begin
                        r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], miso};
                    end
                    if (w_fall) begin
                        if (w_last) begin
                            rx_data           <= r_rx_shift;
                            done              <= 1'b1;
                            busy              <= 1'b0;
                            cs_n              <= 1'b1;
                            clk_divider_reset <= 1'b1;
                            mosi              <= 1'b0;
                        end else begin
                            mosi       <= r_tx_shift[DATA_WIDTH-2];
                            r_tx_shift <= r_tx_shift << 1;
                            r_bit_cnt  <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                c_DONE: done <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_shift_engine
// Description : Scoreboard bench for spi_shift_engine with a clk/32 divider
//               model, loopback or patterned miso and randomized words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_shift_engine;

    localparam int DW    = 8;
    localparam int c_WIN = 32 * DW + 1;

    typedef struct {
        logic [DW-1:0] tx;
        logic [DW-1:0] rx;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          miso;
    logic          sclk_in;
    logic          clk_divider_reset;
    logic          busy;
    logic          done;
    logic [DW-1:0] rx_data;
    logic          cs_n;
    logic          sclk_out;
    logic          mosi;

    logic [4:0]    r_div = '0;
    bit            loop_mode = 1'b1;
    logic [DW-1:0] miso_word = '0;
    int            fall_cnt = 0;
    int            fall_base = 0;
    logic [DW-1:0] mosi_bits = '0;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;
    int   low_cnt = 0;
    bit   done_prev = 1'b0;

    spi_shift_engine #(.DATA_WIDTH(DW)) dut (
        .clk              (clk),
        .reset            (reset),
        .sclk_in          (sclk_in),
        .clk_divider_reset(clk_divider_reset),
        .start            (start),
        .tx_data          (tx_data),
        .busy             (busy),
        .done             (done),
        .rx_data          (rx_data),
        .cs_n             (cs_n),
        .sclk_out         (sclk_out),
        .mosi             (mosi),
        .miso             (miso)
    );

    always #5 clk = ~clk;

    // clock_devider: free-running 5-bit counter held at 0 by its reset
    always @(posedge clk) begin
        if (clk_divider_reset) r_div <= '0;
        else                   r_div <= r_div + 5'd1;
    end
    assign sclk_in = r_div[4];

    // Slave side: miso word presented MSB first, advancing after each sclk fall
    always @(negedge sclk_out) fall_cnt <= fall_cnt + 1;
    always @(posedge sclk_out) mosi_bits <= {mosi_bits[DW-2:0], mosi};

    always_comb begin
        int k;
        k = fall_cnt - fall_base;
        if (k > DW - 1) k = DW - 1;
        if (k < 0) k = 0;
        miso = loop_mode ? mosi : miso_word[DW-1-k];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every done pops one expected transfer
    always @(negedge clk) begin
        if (reset) begin
            low_cnt   = 0;
            done_prev = 1'b0;
        end else begin
            if (done_prev) chk("done_single_cycle", {31'd0, done}, 32'd0);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rx_data", {24'd0, rx_data}, {24'd0, e.rx});
                    chk("mosi_bits", {24'd0, mosi_bits}, {24'd0, e.tx});
                    chk("cs_low_cycles", low_cnt, c_WIN);
                end
                low_cnt = 0;
            end else if (cs_n === 1'b0) begin
                low_cnt++;
            end
            done_prev = done;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cs_n"}, {31'd0, cs_n}, 32'd1);
        chk({tag, "_div_rst"}, {31'd0, clk_divider_reset}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
        chk({tag, "_sclk_out"}, {31'd0, sclk_out}, 32'd0);
        chk({tag, "_mosi"}, {31'd0, mosi}, 32'd0);
    endtask

    // One transfer; abort_at >= 0 asserts reset after that edge instead of finishing
    task automatic xfer(input logic [DW-1:0] tx, input bit loop, input logic [DW-1:0] mw,
                        input bit inject, input int abort_at);
        exp_t x;
        bit   seen;
        int   edge_at;
        @(negedge clk);
        loop_mode = loop;
        miso_word = mw;
        fall_base = fall_cnt;
        start     = 1'b1;
        tx_data   = tx;
        if (abort_at < 0) begin
            x.tx = tx;
            x.rx = loop ? tx : mw;
            sb.push_back(x);
        end
        seen    = 1'b0;
        edge_at = -1;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            start   = 1'b0;
            tx_data = DW'($urandom);
            if (inject && (i == 39 || i == 256)) begin
                start   = 1'b1;
                tx_data = '1;
            end
            if (i == abort_at) begin
                #1 reset = 1'b1;
                #1 check_reset_outputs("abort");
                sb.delete();
                start = 1'b0;
                repeat (3) @(negedge clk);
                reset = 1'b0;
                repeat (2) @(negedge clk);
                return;
            end
            if (done === 1'b1) begin
                seen    = 1'b1;
                edge_at = i;
            end
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        chk("done_edge", edge_at, c_WIN);
    endtask

    initial begin
        #1 reset = 1'b1;
        #1 check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        xfer(8'hA5, 1'b1, 8'h00, 1'b0, -1);
        xfer(8'h00, 1'b0, 8'h3C, 1'b0, -1);

        xfer(8'hC3, 1'b1, 8'h00, 1'b1, -1);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            start = 1'b0;
            chk("busy_after_ignored", {31'd0, busy}, 32'd0);
        end

        xfer(8'h81, 1'b1, 8'h00, 1'b0, -1);
        xfer(8'h7E, 1'b1, 8'h00, 1'b0, -1);

        xfer(8'h99, 1'b1, 8'h00, 1'b0, 99);
        xfer(8'h5A, 1'b1, 8'h00, 1'b0, -1);
        xfer(DW'($urandom), 1'b0, DW'($urandom), 1'b0, 120);

        for (int j = 0; j < 12; j++) begin
            xfer(DW'($urandom), 1'($urandom_range(0, 1)), DW'($urandom), 1'b0, -1);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
